tick_countdown_timer: RTL and testbench

- Consumer end of the decisecond pulse interface: drives `run`/`counterReset` into pulseGenerator and counts its `pulse` output down from a loaded value.
- Signals expiry to the lock controller.
- Used for the lock's entry timeout and the wrong-code lockout period.
- Sits between pulseGenerator and the top-level lock FSM.

---
 rtl/comblock_pkg.sv | 21 ++
 rtl/tick_countdown_timer_if.sv | 42 ++++
 rtl/tick_countdown_timer.sv | 147 ++++++++++++++
 tb/tb_tick_countdown_timer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comblock_pkg.sv
// Shared lock-block definitions: timer state encoding, default timer sizing
// and the decisecond tick rate delivered by pulseGenerator.
package comblock_pkg;

    localparam logic [1:0] TIMER_IDLE    = 2'd0;
    localparam logic [1:0] TIMER_RUNNING = 2'd1;
    localparam logic [1:0] TIMER_PAUSED  = 2'd2;
    localparam logic [1:0] TIMER_EXPIRED = 2'd3;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_WARN_TICKS = 10;
    localparam int TICKS_PER_SECOND   = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = TIMER_IDLE,
        ST_RUNNING = TIMER_RUNNING,
        ST_PAUSED  = TIMER_PAUSED,
        ST_EXPIRED = TIMER_EXPIRED
    } timer_state_e;

endpackage

// File: rtl/tick_countdown_timer_if.sv
// Control/status bundle between the lock controller (master) and the tick
// countdown timer (slave). The warn line exists only with TICK_COUNTDOWN_TIMER_WARN_EN.
interface tick_countdown_timer_if
    import comblock_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] loadValue;
    logic             start;
    logic             pause;
    logic             cancel;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             done;
    logic             expired;
`ifdef TICK_COUNTDOWN_TIMER_WARN_EN
    logic             warn;

    modport master (
        output load, loadValue, start, pause, cancel,
        input  remaining, busy, done, expired, warn
    );

    modport slave (
        input  load, loadValue, start, pause, cancel,
        output remaining, busy, done, expired, warn
    );
`else
    modport master (
        output load, loadValue, start, pause, cancel,
        input  remaining, busy, done, expired
    );

    modport slave (
        input  load, loadValue, start, pause, cancel,
        output remaining, busy, done, expired
    );
`endif

endinterface

// File: rtl/tick_countdown_timer.sv
// Counts pulseGenerator ticks down from a loaded value and flags expiry to the
// lock FSM. Optional warn output is built when TICK_COUNTDOWN_TIMER_WARN_EN is defined.
module tick_countdown_timer
    import comblock_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int WARN_TICKS = DEFAULT_WARN_TICKS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    output logic                   run,
    output logic                   counterReset,
    tick_countdown_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_e     state_r;
    timer_state_e     state_s;
    logic [WIDTH-1:0] remaining_r;
    logic [WIDTH-1:0] remaining_s;
    logic             crst_s;
    logic             expire_s;
    logic             run_r;
    logic             crst_r;
    logic             busy_r;
    logic             done_r;
    logic             expired_r;

    // Next state and next count; cancel overrides every other request.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        crst_s      = 1'b0;
        expire_s    = 1'b0;
        if (bus.cancel) begin
            state_s     = ST_IDLE;
            remaining_s = ZERO;
            crst_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load) begin
                        remaining_s = bus.loadValue;
                    end else if (bus.start) begin
                        if (remaining_r == ZERO) begin
                            state_s  = ST_EXPIRED;
                            expire_s = 1'b1;
                        end else begin
                            // Restart the pulse generator so the first period is full length.
                            state_s = ST_RUNNING;
                            crst_s  = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (bus.pause) begin
                        state_s = ST_PAUSED;
                    end else if (tick && (remaining_r != ZERO)) begin
                        remaining_s = remaining_r - ONE;
                        if (remaining_r == ONE) begin
                            state_s  = ST_EXPIRED;
                            expire_s = 1'b1;
                        end else begin
                            state_s = ST_RUNNING;
                        end
                    end else begin
                        state_s = ST_RUNNING;
                    end
                end
                ST_PAUSED: begin
                    // Resume without counterReset so the partial period is kept.
                    if (bus.start) begin
                        state_s = ST_RUNNING;
                    end else begin
                        state_s = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
                    if (bus.load) begin
                        remaining_s = bus.loadValue;
                        state_s     = ST_IDLE;
                    end else begin
                        state_s = ST_EXPIRED;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    remaining_s = ZERO;
                end
            endcase
        end
    end

    // State, count and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= ZERO;
            run_r       <= 1'b0;
            crst_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            expired_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            run_r       <= (state_s == ST_RUNNING);
            crst_r      <= crst_s;
            busy_r      <= (state_s == ST_RUNNING) || (state_s == ST_PAUSED);
            done_r      <= (state_s == ST_EXPIRED);
            expired_r   <= expire_s;
        end
    end

`ifdef TICK_COUNTDOWN_TIMER_WARN_EN
    // Threshold saturates to the largest count when it does not fit in WIDTH.
    localparam logic [WIDTH-1:0] WARN_LIMIT =
        (WARN_TICKS >= (2 ** WIDTH)) ? {WIDTH{1'b1}} : WIDTH'(WARN_TICKS);

    logic warn_r;

    // Warning window evaluated on the next count so it lines up with remaining.
    always_ff @(posedge clock) begin
        if (reset) begin
            warn_r <= 1'b0;
        end else begin
            warn_r <= ((state_s == ST_RUNNING) || (state_s == ST_PAUSED))
                      && (remaining_s != ZERO) && (remaining_s <= WARN_LIMIT);
        end
    end

    assign bus.warn = warn_r;
`endif

    assign run           = run_r;
    assign counterReset  = crst_r;
    assign bus.remaining = remaining_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.expired   = expired_r;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Scoreboard bench for tick_countdown_timer: each stimulus row carries the
// outputs expected one clock later, compared at the following falling edge.
module tb_tick_countdown_timer;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic             rst;
        logic             cancel;
        logic             load;
        logic [WIDTH-1:0] val;
        logic             start;
        logic             pause;
        logic             tick;
    } stim_t;

    typedef struct packed {
        logic [WIDTH-1:0] rem;
        logic             run;
        logic             crst;
        logic             busy;
        logic             done;
        logic             expd;
        logic             warn;
    } obs_t;

    logic clock = 1'b0;
    logic reset;
    logic tick;
    logic run;
    logic counterReset;

    tick_countdown_timer_if #(.WIDTH(WIDTH)) tif ();

    tick_countdown_timer #(.WIDTH(WIDTH), .WARN_TICKS(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .run          (run),
        .counterReset (counterReset),
        .bus          (tif)
    );

    always #5 clock = ~clock;

    int    errors = 0;
    int    checks = 0;
    stim_t stim_q[$];
    obs_t  exp_q[$];
    obs_t  sb[$];

    function automatic stim_t s_mk(input logic rst, input logic cancel, input logic load,
                                   input logic [WIDTH-1:0] val, input logic start,
                                   input logic pause, input logic tk);
        stim_t s;
        s.rst = rst; s.cancel = cancel; s.load = load; s.val = val;
        s.start = start; s.pause = pause; s.tick = tk;
        return s;
    endfunction

    function automatic stim_t s_idle();  return s_mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); endfunction
    function automatic stim_t s_rst();   return s_mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); endfunction
    function automatic stim_t s_start(); return s_mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0); endfunction
    function automatic stim_t s_pause(); return s_mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0); endfunction
    function automatic stim_t s_tick();  return s_mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); endfunction
    function automatic stim_t s_load(input logic [WIDTH-1:0] v);
        return s_mk(1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
    endfunction

    // Expected outputs; warn follows its own rule from busy and remaining.
    function automatic obs_t e_mk(input logic [WIDTH-1:0] rem, input logic r, input logic c,
                                  input logic b, input logic d, input logic x);
        obs_t o;
        o.rem = rem; o.run = r; o.crst = c; o.busy = b; o.done = d; o.expd = x;
`ifdef TICK_COUNTDOWN_TIMER_WARN_EN
        o.warn = b && (rem != 8'd0) && (rem <= 8'd10);
`else
        o.warn = 1'b0;
`endif
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.rem = tif.remaining; o.run = run; o.crst = counterReset;
        o.busy = tif.busy; o.done = tif.done; o.expd = tif.expired;
`ifdef TICK_COUNTDOWN_TIMER_WARN_EN
        o.warn = tif.warn;
`else
        o.warn = 1'b0;
`endif
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("rem=%0d run=%b counterReset=%b busy=%b done=%b expired=%b warn=%b",
                         o.rem, o.run, o.crst, o.busy, o.done, o.expd, o.warn);
    endfunction

    task automatic add(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Apply one row on the falling edge and let one rising edge consume it.
    task automatic drive(input stim_t s);
        reset          = s.rst;
        tif.cancel     = s.cancel;
        tif.load       = s.load;
        tif.loadValue  = s.val;
        tif.start      = s.start;
        tif.pause      = s.pause;
        tick           = s.tick;
        sb.push_back(exp_q.pop_front());
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_basic();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd3), e_mk(8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int r = 3; r >= 1; r--) begin
            for (int k = 0; k < 4; k++) add(s_idle(), e_mk(WIDTH'(r), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            if (r > 1) add(s_tick(), e_mk(WIDTH'(r - 1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            else       add(s_tick(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        add(s_idle(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_pause_resume();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd5), e_mk(8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_pause(), e_mk(8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_load(8'd9), e_mk(8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        add(s_tick(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pause_resume step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd1), e_mk(8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1), e_mk(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd4), e_mk(8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        add(s_mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1), e_mk(8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL simultaneous step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_zero_load();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd0), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        add(s_start(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        add(s_tick(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        add(s_load(8'd7), e_mk(8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_tick(), e_mk(8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd255), e_mk(8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0), e_mk(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL zero_load step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd200), e_mk(8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k <= 10; k++) add(s_tick(), e_mk(WIDTH'(200 - k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_load(8'd5), e_mk(8'd190, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_idle(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid_run step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_warn();
        obs_t g, e;
        add(s_rst(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_load(8'd12), e_mk(8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(s_start(), e_mk(8'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int r = 12; r >= 1; r--) begin
            if (r > 1) add(s_tick(), e_mk(WIDTH'(r - 1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            else       add(s_tick(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        add(s_idle(), e_mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int step = 0; stim_q.size() > 0; step++) begin
            drive(stim_q.pop_front());
            g = sample(); e = sb.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL warn step %0d: got %s, expected %s", step, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        tick          = 1'b0;
        tif.cancel    = 1'b0;
        tif.load      = 1'b0;
        tif.loadValue = 8'd0;
        tif.start     = 1'b0;
        tif.pause     = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_pause_resume();
        test_simultaneous();
        test_zero_load();
        test_reset_mid_run();
        test_warn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
